// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and (future) transmit blocks.
//   - Default line constants used by both directions.
//   - One-hot receiver FSM state encoding.
//   - Baud tick divisor calculation.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 9600;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_SB_TICK   = 16;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    STOP  = 5'b01000,
    BREAK = 5'b10000
  } rx_state_t;

  // Clocks per oversample tick. Integer division; clamped to 2 so the tick
  // generator always has a real counter behind it.
  function automatic int calc_divisor(input int clk_freq, input int baud_rate,
                                      input int oversample);
    int div;
    div = clk_freq / (baud_rate * oversample);
    if (div < 2) div = 2;
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_baud_rate_gen.sv
// Free-running oversample tick generator.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset (counter to 0)
//   tick  - one-clk pulse every DIVISOR clocks (when counter == DIVISOR-1)
module baud_rate_gen #(
  parameter int DIVISOR = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver, LSB first, for the debug link.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-high reset
//   rx        - serial line, idle high, asynchronous to clk
//   d_out     - last correctly framed byte, held until the next good frame
//   rx_done   - one-clk strobe, d_out carries a new byte this cycle
//   frame_err - one-clk strobe, stop bit was sampled low
//   busy      - high whenever the receiver FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int SB_TICK    = DEFAULT_SB_TICK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [SIZE-1:0] d_out,
  output logic            rx_done,
  output logic            frame_err,
  output logic            busy
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int NW      = $clog2(SIZE);
  localparam logic [NW-1:0] LAST_BIT  = NW'(SIZE - 1);
  localparam logic [3:0]    STOP_LAST = 4'(SB_TICK - 1);

  logic tick;

  baud_rate_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic            sync1_q, sync1_d;
  logic            rx_s_q, rx_s_d;
  rx_state_t       state_q, state_d;
  logic [3:0]      s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [SIZE-1:0] shreg_q, shreg_d;
  logic [SIZE-1:0] d_out_q, d_out_d;
  logic            rx_done_q, rx_done_d;
  logic            frame_err_q, frame_err_d;

  always_comb begin
    // Two-flop synchronizer; everything downstream sees only rx_s_q.
    sync1_d     = rx;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    shreg_d     = shreg_q;
    d_out_d     = d_out_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          // Mid start bit: a line that is high again was only a glitch.
          if (s_cnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_q == 4'd15) begin
            shreg_d = {rx_s_q, shreg_q[SIZE-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == LAST_BIT) state_d = STOP;
            else                     n_cnt_d = n_cnt_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt_q == STOP_LAST) begin
            if (rx_s_q) begin
              d_out_d   = shreg_q;
              rx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      BREAK: begin
        // Held-low line: stay here so a long break reports only once.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      shreg_q     <= '0;
      d_out_q     <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      shreg_q     <= shreg_d;
      d_out_q     <= d_out_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign d_out     = d_out_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule
